bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares one port (port A) of a true dual-port block RAM between NUM_REQ on-chip requesters.
- Each requester issues single-word read or write commands through a valid/ready handshake.
- Arbitration is round-robin, and read data is returned tagged with the requester ID after the fixed RAM read latency.
- Includes a clear sequencer that zero-fills the RAM after reset and on command, so the RAM contents are known before clients start.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 10, RAM address width
- DATA_WIDTH, 18, RAM word width
- RAM_DEPTH, 1024, number of words cleared by the clear sequence (≤ 2**ADDR_WIDTH)
- READ_LATENCY, 2, cycles from ram_en+address to valid ram_dout (2 = output-registered RAM, 1 = low-latency RAM)

Ports:
- clka  in  1  clock, shared with RAM port A
- rstb  in  1  reset, synchronous, active-high
- clear_req  in  1  single-cycle pulse: re-zero the whole RAM
- init_done  out  1  high when the clear sequence is not running
- req_valid  in  NUM_REQ  per-requester command valid
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_ready  out  NUM_REQ  one-hot grant; command accepted when valid&ready
- rsp_valid  out  1  read data valid (no backpressure)
- rsp_id  out  $clog2(NUM_REQ)  requester that issued the read
- rsp_data  out  DATA_WIDTH  read data
- ram_addr  out  ADDR_WIDTH  to RAM addra
- ram_din  out  DATA_WIDTH  to RAM dina
- ram_we  out  1  to RAM wea
- ram_en  out  1  to RAM ena
- ram_regce  out  1  to RAM regcea, constant 1
- ram_rst  out  1  to RAM rsta, equals rstb
- ram_dout  in  DATA_WIDTH  from RAM douta

Behaviour:
- Reset: while rstb is high, all registered outputs are 0: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, init_done=0. The FSM enters CLEAR with clear_addr=0 and rr_ptr=0, and the read tracking pipe is flushed.
- FSM, state CLEAR:
  - Each cycle drives ram_en=1, ram_we=1, ram_addr=clear_addr, ram_din=0, then clear_addr increments.
  - req_ready=0 and init_done=0.
  - After writing RAM_DEPTH-1, the FSM goes to RUN on the next cycle, so CLEAR lasts exactly RAM_DEPTH cycles.
- FSM, state RUN:
  - init_done=1.
  - Grant is combinational: the winner is the first requester with req_valid set, scanning from rr_ptr upward with wrap.
  - req_ready is one-hot on the winner, or all 0 if no request is pending.
  - On a grant to requester k: ram_en=1, ram_we=req_we[k], ram_addr/ram_din taken from slice k, and rr_ptr updates to (k+1) mod NUM_REQ at the clock edge.
  - With no grant: ram_en=0 and ram_we=0, and rr_ptr holds.
  - At most one command is granted per cycle, giving a throughput of 1 command per cycle.
- clear_req:
  - Sampled in RUN. On the cycle it is seen, no grant is issued (req_ready=0), and the FSM goes to CLEAR next cycle with clear_addr=0.
  - Ignored while already in CLEAR; the sweep is not restarted.
- Read return:
  - A READ_LATENCY-deep shift pipe carries {valid, id} for each granted read.
  - rsp_valid/rsp_id come from the pipe tail, and rsp_data=ram_dout in the same cycle.
  - A read granted in cycle T gives rsp_valid=1 in cycle T+READ_LATENCY.
  - Writes never produce a response.
  - Reads in flight when a clear begins still complete, returning pre-clear data.
- Ordering:
  - Port A operates in read-first mode, so a read and a write to the same address in consecutive cycles return correct program-order data.
  - The block adds no bypass.
  - Port B conflicts are outside this block's scope.
- rsp_data is the raw RAM output qualified by rsp_valid; its value while rsp_valid=0 is unspecified, and benches must not check it.
- The requester holds valid/we/addr/wdata stable until accepted, and must not deassert valid before acceptance.

Decomposition:
- Shared package (bram_arb_pkg) holds:
  - FSM state enum {CLEAR, RUN}
  - ID width constant
  - the packed slice-index helper
- One sub-module: rr_arbiter (NUM_REQ requests plus pointer in, one-hot grant plus encoded index out, purely combinational). The pointer register stays in the top level.

Test Plan:
- Reset then idle, RAM_DEPTH=16: ram_we=1 for exactly 16 cycles with addresses 0..15 and din=0, then init_done=1. A read of address 5 returns 0 two cycles after grant.
- Requester 1 writes 0x2A5 to address 7, then requester 2 reads address 7 the next cycle: rsp_valid=1 two cycles after the read grant, rsp_id=2, rsp_data=0x2A5.
- All 4 requesters hold valid continuously from rr_ptr=0: grants follow 0,1,2,3,0,… with one grant per cycle and no requester granted twice within any 4 consecutive cycles.
- Back-to-back reads by requesters 3,0,1 to addresses 1,2,3 (preloaded 0x11,0x22,0x33): three consecutive rsp_valid cycles with ids 3,0,1 and data 0x11,0x22,0x33.
- A read grant in cycle T followed by clear_req in T+1: the response still arrives at T+2 with the old data, req_ready=0 for RAM_DEPTH+1 cycles, then a read of the same address returns 0.
- rstb asserted mid-CLEAR and mid-read: the next cycle shows all outputs 0 and no stale rsp_valid, and the clear restarts from address 0.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the block-RAM port-A arbiter.
// Holds the FSM state encoding, requester-ID width and packed-slice indexing.
package bram_arb_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } arb_state_e;

    localparam int unsigned MAX_NUM_REQ  = 8;
    localparam int unsigned MAX_ID_WIDTH = 3;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Low bit of element idx inside a packed bus of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first request found scanning upward
// from ptr (with wrap) wins; one-hot grant plus its encoded index.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    int best_dist_s;
    int best_k_s;
    int dist_s;
    int ptr_i_s;

    // Pick the requester with the smallest rotational distance from ptr.
    always_comb begin
        best_dist_s = NUM_REQ;
        best_k_s    = 0;
        dist_s      = 0;
        ptr_i_s     = int'(ptr);
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            dist_s = (k >= ptr_i_s) ? (k - ptr_i_s) : (k + NUM_REQ - ptr_i_s);
            if (req[k] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                best_k_s    = k;
            end else begin
                best_dist_s = best_dist_s;
            end
        end
        grant_valid = (best_dist_s < NUM_REQ);
        grant_idx   = ID_W'(best_k_s);
        for (int k = 0; k < NUM_REQ; k++) begin
            grant[k] = grant_valid && (k == best_k_s);
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares RAM port A between NUM_REQ requesters with round-robin arbitration,
// tagged read return after READ_LATENCY, and a zero-fill sequence after reset.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 18,
    parameter int RAM_DEPTH    = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                          clka,
    input  logic                          rstb,
    input  logic                          clear_req,
    output logic                          init_done,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    output logic                          ram_we,
    output logic                          ram_en,
    output logic                          ram_regce,
    output logic                          ram_rst,
    input  logic [DATA_WIDTH-1:0]         ram_dout
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_e              state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0]   clear_addr_r, clear_addr_nxt_s;
    logic [ID_W-1:0]         rr_ptr_r, rr_ptr_nxt_s;
    logic [READ_LATENCY-1:0] pipe_valid_r;
    logic [ID_W-1:0]         pipe_id_r [READ_LATENCY];

    logic [NUM_REQ-1:0]      grant_s;
    logic [ID_W-1:0]         grant_idx_s;
    logic                    grant_valid_s;
    logic                    sel_we_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_din_s;
    logic                    rd_issue_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (rr_ptr_r),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // AND-OR mux of the winning requester's command fields (grant is one-hot).
    always_comb begin
        sel_we_s   = 1'b0;
        sel_addr_s = '0;
        sel_din_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_we_s   = sel_we_s | (req_we[k] & grant_s[k]);
            sel_addr_s = sel_addr_s |
                         (req_addr[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH] & {ADDR_WIDTH{grant_s[k]}});
            sel_din_s  = sel_din_s |
                         (req_wdata[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH] & {DATA_WIDTH{grant_s[k]}});
        end
    end

    // Next-state and RAM port drive for the clear sweep and normal arbitration.
    always_comb begin
        state_nxt_s      = state_r;
        clear_addr_nxt_s = clear_addr_r;
        rr_ptr_nxt_s     = rr_ptr_r;
        ram_en           = 1'b0;
        ram_we           = 1'b0;
        ram_addr         = '0;
        ram_din          = '0;
        req_ready        = '0;
        rd_issue_s       = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = clear_addr_r;
                if (clear_addr_r == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                    state_nxt_s      = ST_RUN;
                    clear_addr_nxt_s = '0;
                end else begin
                    clear_addr_nxt_s = clear_addr_r + ADDR_WIDTH'(1);
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    // The clear cycle itself grants nothing.
                    state_nxt_s      = ST_CLEAR;
                    clear_addr_nxt_s = '0;
                end else if (grant_valid_s) begin
                    req_ready    = grant_s;
                    ram_en       = 1'b1;
                    ram_we       = sel_we_s;
                    ram_addr     = sel_addr_s;
                    ram_din      = sel_din_s;
                    rd_issue_s   = ~sel_we_s;
                    rr_ptr_nxt_s = (grant_idx_s == ID_W'(NUM_REQ - 1)) ?
                                   '0 : (grant_idx_s + ID_W'(1));
                end else begin
                    rr_ptr_nxt_s = rr_ptr_r;
                end
            end
            default: begin
                state_nxt_s      = ST_CLEAR;
                clear_addr_nxt_s = '0;
            end
        endcase
        if (rstb) begin
            ram_en     = 1'b0;
            ram_we     = 1'b0;
            req_ready  = '0;
            rd_issue_s = 1'b0;
        end else begin
            rd_issue_s = rd_issue_s;
        end
    end

    // State, sweep address, RR pointer and read-tracking pipe registers.
    always_ff @(posedge clka) begin
        if (rstb) begin
            state_r      <= ST_CLEAR;
            clear_addr_r <= '0;
            rr_ptr_r     <= '0;
            pipe_valid_r <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_id_r[i] <= '0;
            end
        end else begin
            state_r         <= state_nxt_s;
            clear_addr_r    <= clear_addr_nxt_s;
            rr_ptr_r        <= rr_ptr_nxt_s;
            pipe_valid_r[0] <= rd_issue_s;
            pipe_id_r[0]    <= rd_issue_s ? grant_idx_s : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_id_r[i]    <= pipe_id_r[i-1];
            end
        end
    end

    assign rsp_valid = pipe_valid_r[READ_LATENCY-1] & ~rstb;
    assign rsp_id    = rsp_valid ? pipe_id_r[READ_LATENCY-1] : '0;
    assign rsp_data  = rsp_valid ? ram_dout : '0;
    assign init_done = (state_r == ST_RUN) & ~rstb;
    assign ram_regce = 1'b1;
    assign ram_rst   = rstb;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized bench for bram_port_arbiter with a read-first RAM model and a
// transaction-level reference (memory image, RR pointer, response queue).
module tb_bram_port_arbiter;

    localparam int NR    = 4;
    localparam int AW    = 10;
    localparam int DW    = 18;
    localparam int DEPTH = 16;
    localparam int LAT   = 2;
    localparam int NCYC  = 3000;

    logic              clka = 1'b0;
    logic              rstb;
    logic              clear_req;
    logic              init_done;
    logic [NR-1:0]     req_valid, req_we, req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_data;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_din, ram_dout;
    logic              ram_we, ram_en, ram_regce, ram_rst;

    bram_port_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .RAM_DEPTH(DEPTH), .READ_LATENCY(LAT)
    ) dut (
        .clka(clka), .rstb(rstb), .clear_req(clear_req), .init_done(init_done),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_we(ram_we), .ram_en(ram_en),
        .ram_regce(ram_regce), .ram_rst(ram_rst), .ram_dout(ram_dout)
    );

    always #5 clka = ~clka;

    // Read-first RAM with an output register (two-cycle read latency).
    logic [DW-1:0] ram_mem [1024];
    logic [DW-1:0] ram_s1;
    always @(posedge clka) begin
        if (ram_rst) begin
            ram_s1   <= '0;
            ram_dout <= '0;
        end else begin
            if (ram_en) begin
                ram_s1 <= ram_mem[ram_addr];
                if (ram_we) ram_mem[ram_addr] <= ram_din;
            end
            ram_dout <= ram_s1;
        end
    end

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          rsp_q[$];
    logic [DW-1:0] mdl_mem [DEPTH];
    int            mdl_ptr;
    int            clear_left;
    bit            p_valid [NR];
    bit            p_we    [NR];
    int            p_addr  [NR];
    logic [DW-1:0] p_wdata [NR];

    initial begin
        bit rst_now, clr_now;
        int prob, w;
        logic [NR-1:0] exp_ready;
        rsp_t r;

        for (int i = 0; i < NR; i++) p_valid[i] = 1'b0;
        rstb = 1'b1; clear_req = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        mdl_ptr = 0; clear_left = DEPTH;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clka); #1;
            rst_now = (cyc < 3) || (cyc == 1200) || (cyc == 2507);
            clr_now = !rst_now && ((cyc == 2500) || ($urandom_range(0, 399) == 0));
            // Saturating phase exercises strict round-robin rotation.
            prob = (cyc >= 300 && cyc < 500) ? 100 : 40;
            for (int i = 0; i < NR; i++) begin
                if (rst_now) begin
                    p_valid[i] = 1'b0;
                end else if (!p_valid[i] && ($urandom_range(0, 99) < prob)) begin
                    p_valid[i] = 1'b1;
                    p_we[i]    = 1'($urandom_range(0, 1));
                    p_addr[i]  = $urandom_range(0, DEPTH - 1);
                    p_wdata[i] = DW'($urandom);
                end
                req_valid[i]           = p_valid[i];
                req_we[i]              = p_we[i];
                req_addr[i*AW +: AW]   = AW'(p_addr[i]);
                req_wdata[i*DW +: DW]  = p_wdata[i];
            end
            rstb      = rst_now;
            clear_req = clr_now;

            @(negedge clka);
            check_eq("ram_rst", 64'(ram_rst), 64'(rst_now));
            check_eq("ram_regce", 64'(ram_regce), 64'd1);
            if (rst_now) begin
                check_eq("rst_ready", 64'(req_ready), 64'd0);
                check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
                check_eq("rst_rsp_id", 64'(rsp_id), 64'd0);
                check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
                check_eq("rst_init_done", 64'(init_done), 64'd0);
                check_eq("rst_ram_en", 64'(ram_en), 64'd0);
                rsp_q.delete();
                mdl_ptr    = 0;
                clear_left = DEPTH;
            end else begin
                if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                    r = rsp_q.pop_front();
                    check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
                    check_eq("rsp_id", 64'(rsp_id), 64'(r.id));
                    check_eq("rsp_data", 64'(rsp_data), 64'(r.data));
                end else begin
                    check_eq("rsp_valid_idle", 64'(rsp_valid), 64'd0);
                end

                if (clear_left > 0) begin
                    check_eq("clr_init_done", 64'(init_done), 64'd0);
                    check_eq("clr_ready", 64'(req_ready), 64'd0);
                    check_eq("clr_en_we", 64'({ram_en, ram_we}), 64'd3);
                    check_eq("clr_addr", 64'(ram_addr), 64'(DEPTH - clear_left));
                    check_eq("clr_din", 64'(ram_din), 64'd0);
                    mdl_mem[DEPTH - clear_left] = '0;
                    clear_left--;
                end else begin
                    check_eq("run_init_done", 64'(init_done), 64'd1);
                    if (clr_now) begin
                        check_eq("clrreq_ready", 64'(req_ready), 64'd0);
                        check_eq("clrreq_en", 64'(ram_en), 64'd0);
                        clear_left = DEPTH;
                    end else begin
                        w = -1;
                        for (int off = 0; off < NR; off++) begin
                            if (w < 0 && p_valid[(mdl_ptr + off) % NR]) w = (mdl_ptr + off) % NR;
                        end
                        exp_ready = (w >= 0) ? NR'(1 << w) : '0;
                        check_eq("grant", 64'(req_ready), 64'(exp_ready));
                        if (w >= 0) begin
                            check_eq("g_en", 64'(ram_en), 64'd1);
                            check_eq("g_we", 64'(ram_we), 64'(p_we[w]));
                            check_eq("g_addr", 64'(ram_addr), 64'(p_addr[w]));
                            check_eq("g_din", 64'(ram_din), 64'(p_wdata[w]));
                            if (p_we[w]) begin
                                mdl_mem[p_addr[w]] = p_wdata[w];
                            end else begin
                                r.due = cyc + LAT; r.id = w; r.data = mdl_mem[p_addr[w]];
                                rsp_q.push_back(r);
                            end
                            p_valid[w] = 1'b0;
                            mdl_ptr    = (w + 1) % NR;
                        end else begin
                            check_eq("idle_en_we", 64'({ram_en, ram_we}), 64'd0);
                        end
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
